// File: rtl/ipif_table_store.sv
// ipif_table_store: row-oriented table storage behind the IPIF table-register
// front end. A register-side read/write client (req/ack) and a single-cycle
// datapath lookup port share the table; register accesses yield to lookups
// for at most MAX_DEFER consecutive cycles, then are forced through.
// Optional build macro: TBL_STORE_STATS_EN adds lookup/deferral counters.
//
// Handshakes:
//   register side: req is held high until the matching ack pulse is seen and
//   dropped the cycle after; ack is a one-cycle pulse.
//   lookup side: a lookup is accepted on a rising edge where lkup_req and
//   lkup_rdy are both high; lkup_vld/lkup_data follow one cycle later.
module ipif_table_store #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_NUM_COLS       = 4,
  parameter int TBL_NUM_ROWS       = 4,
  parameter int MAX_DEFER          = 8,
  localparam int AW  = (TBL_NUM_ROWS > 1) ? $clog2(TBL_NUM_ROWS) : 1,
  localparam int RW  = C_S_AXI_DATA_WIDTH * TBL_NUM_COLS,
  localparam int DFW = $clog2(MAX_DEFER + 1)
) (
  input  logic          Bus2IP_Clk,
  input  logic          Bus2IP_Reset,
  input  logic          tbl_rd_req,
  output logic          tbl_rd_ack,
  input  logic [AW-1:0] tbl_rd_addr,
  output logic [RW-1:0] tbl_rd_data,
  input  logic          tbl_wr_req,
  output logic          tbl_wr_ack,
  input  logic [AW-1:0] tbl_wr_addr,
  input  logic [RW-1:0] tbl_wr_data,
  input  logic          lkup_req,
  input  logic [AW-1:0] lkup_addr,
  output logic          lkup_rdy,
  output logic          lkup_vld,
  output logic [RW-1:0] lkup_data,
  output logic [1:0]    dbg_state
`ifdef TBL_STORE_STATS_EN
  ,
  output logic [31:0]   stat_lkup_cnt,
  output logic [31:0]   stat_defer_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  logic [RW-1:0]  mem [TBL_NUM_ROWS];
  state_t         state;
  logic [DFW-1:0] defer;
  logic           svc_wr;     // serviced request was a write
  logic [RW-1:0]  rd_row;
  logic [RW-1:0]  lk_row;

  logic pending;
  logic forced;
  logic grant;
  logic lkup_acc;

  assign pending   = tbl_wr_req | tbl_rd_req;
  assign forced    = (defer == DFW'(MAX_DEFER));
  assign grant     = (state == ST_IDLE) && pending && (!lkup_req || forced);
  // A forced grant is the only moment the datapath is turned away.
  assign lkup_rdy  = !((state == ST_IDLE) && pending && forced);
  assign lkup_acc  = lkup_req & lkup_rdy;
  assign dbg_state = state;

  // Row selection for both read ports; rows past the table end read as zero.
  always_comb begin
    rd_row = '0;
    lk_row = '0;
    for (int r = 0; r < TBL_NUM_ROWS; r++) begin
      if (tbl_rd_addr == AW'(r)) rd_row = mem[r];
      if (lkup_addr == AW'(r))   lk_row = mem[r];
    end
  end

  // Register-side arbiter/FSM; owns the table contents and register read data.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state       <= ST_IDLE;
      defer       <= '0;
      svc_wr      <= 1'b0;
      tbl_rd_ack  <= 1'b0;
      tbl_wr_ack  <= 1'b0;
      tbl_rd_data <= '0;
      for (int r = 0; r < TBL_NUM_ROWS; r++) mem[r] <= '0;
    end else begin
      tbl_rd_ack <= 1'b0;
      tbl_wr_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            defer  <= '0;
            svc_wr <= tbl_wr_req;
            state  <= ST_ACK;
            if (tbl_wr_req) begin
              // Out-of-range rows match nothing, so the write is dropped.
              for (int r = 0; r < TBL_NUM_ROWS; r++)
                if (tbl_wr_addr == AW'(r)) mem[r] <= tbl_wr_data;
            end else begin
              tbl_rd_data <= rd_row;
            end
          end else if (pending) begin
            // Never reaches past MAX_DEFER: at that value grant is forced.
            defer <= defer + DFW'(1);
          end
        end
        ST_ACK: begin
          tbl_wr_ack <= svc_wr;
          tbl_rd_ack <= !svc_wr;
          state      <= ST_HOLD;
        end
        ST_HOLD: begin
          // Wait for the front end to drop the serviced request.
          if (svc_wr ? !tbl_wr_req : !tbl_rd_req) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath lookup: one-cycle registered read of the row as of acceptance.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      lkup_vld  <= 1'b0;
      lkup_data <= '0;
    end else begin
      lkup_vld <= lkup_acc;
      if (lkup_acc) lkup_data <= lk_row;
    end
  end

`ifdef TBL_STORE_STATS_EN
  // Free-running statistics: accepted lookups and deferred register cycles.
  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      stat_lkup_cnt  <= '0;
      stat_defer_cnt <= '0;
    end else begin
      if (lkup_acc) stat_lkup_cnt <= stat_lkup_cnt + 32'd1;
      if ((state == ST_IDLE) && pending && !grant)
        stat_defer_cnt <= stat_defer_cnt + 32'd1;
    end
  end
`endif

endmodule
